// File: rtl/md5_iter_if.sv
// Block-level bus between the block buffer (master) and md5_iter_core (slave).
interface md5_iter_if;
    // start is a one-shot request taken only when busy is low; no ready signal,
    // busy is the not-ready indication and done marks a fresh digest.
    logic         start;
    logic         first;
    logic [511:0] message;
    logic         busy;
    logic         done;
    logic [127:0] digest;
    logic [1:0]   state_dbg;

    modport master (
        output start, first, message,
        input  busy, done, digest, state_dbg
    );

    modport slave (
        input  start, first, message,
        output busy, done, digest, state_dbg
    );
endinterface

// File: rtl/md5_iter_core.sv
// Iterative MD5 compression, UNROLL steps per clock, chaining value kept internally.
// Define MD5_BYTESWAP_EN for byte-stream message input and byte-ordered digest output.
module md5_iter_core #(
    parameter int UNROLL = 1
) (
    input logic       clk,
    input logic       reset,
    md5_iter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FINAL = 2'd2} state_t;

    localparam logic [31:0] IV_A = 32'h67452301;
    localparam logic [31:0] IV_B = 32'hefcdab89;
    localparam logic [31:0] IV_C = 32'h98badcfe;
    localparam logic [31:0] IV_D = 32'h10325476;
    localparam logic [5:0]  LAST_STEP = 6'(64 - UNROLL);

    localparam logic [31:0] K_ROM [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    // Indexed by {round, step[1:0]}.
    localparam logic [4:0] S_ROM [16] = '{
        5'd7, 5'd12, 5'd17, 5'd22, 5'd5, 5'd9, 5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23, 5'd6, 5'd10, 5'd15, 5'd21
    };

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16)) begin : g_bad_unroll
        $error("md5_iter_core: UNROLL must be 1, 2, 4, 8 or 16");
    end

    function automatic logic [3:0] g_rom(input logic [5:0] i);
        logic [3:0] j;
        logic [3:0] g;
        j = i[3:0];
        case (i[5:4])
            2'd0:    g = j;
            2'd1:    g = 4'(j * 4'd5 + 4'd1);
            2'd2:    g = 4'(j * 4'd3 + 4'd5);
            default: g = 4'(j * 4'd7);
        endcase
        return g;
    endfunction

    function automatic logic [31:0] f_fn(input logic [1:0] r, input logic [31:0] b, c, d);
        logic [31:0] f;
        case (r)
            2'd0:    f = (b & c) | (~b & d);
            2'd1:    f = (d & b) | (~d & c);
            2'd2:    f = b ^ c ^ d;
            default: f = c ^ (b | ~d);
        endcase
        return f;
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
        return (x << s) | (x >> (6'd32 - {1'b0, s}));
    endfunction

`ifdef MD5_BYTESWAP_EN
    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction
`endif

    state_t            r_state, w_next_state;
    logic              w_accept;
    logic [15:0][31:0] r_m, w_msg_words;
    logic [31:0]       r_a, r_b, r_c, r_d;
    logic [31:0]       r_h0, r_h1, r_h2, r_h3;
    logic [31:0]       w_a, w_b, w_c, w_d;
    logic [31:0]       w_h0, w_h1, w_h2, w_h3;
    logic [127:0]      w_digest, r_digest;
    logic [5:0]        r_step;
    logic              r_done;

    always_comb begin
        for (int i = 0; i < 16; i++) begin
`ifdef MD5_BYTESWAP_EN
            w_msg_words[i] = bswap(bus.message[511 - 32*i -: 32]);
`else
            w_msg_words[i] = bus.message[32*i +: 32];
`endif
        end
    end

    // UNROLL chained MD5 steps starting at r_step.
    always_comb begin : p_round
        logic [31:0] va, vb, vc, vd, vt;
        logic [5:0]  idx;
        va = r_a; vb = r_b; vc = r_c; vd = r_d;
        vt = '0;
        idx = '0;
        for (int u = 0; u < UNROLL; u++) begin
            idx = r_step + 6'(u);
            vt = va + f_fn(idx[5:4], vb, vc, vd) + K_ROM[idx] + r_m[g_rom(idx)];
            va = vd;
            vd = vc;
            vc = vb;
            vb = vb + rotl(vt, S_ROM[{idx[5:4], idx[1:0]}]);
        end
        w_a = va; w_b = vb; w_c = vc; w_d = vd;
    end

    assign w_h0 = r_h0 + r_a;
    assign w_h1 = r_h1 + r_b;
    assign w_h2 = r_h2 + r_c;
    assign w_h3 = r_h3 + r_d;
`ifdef MD5_BYTESWAP_EN
    assign w_digest = {bswap(w_h0), bswap(w_h1), bswap(w_h2), bswap(w_h3)};
`else
    assign w_digest = {w_h0, w_h1, w_h2, w_h3};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_next_state = RUN;
                end
            end
            RUN:     if (r_step == LAST_STEP) w_next_state = FINAL;
            FINAL:   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m      <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_d      <= '0;
            r_h0     <= IV_A;
            r_h1     <= IV_B;
            r_h2     <= IV_C;
            r_h3     <= IV_D;
            r_step   <= '0;
            r_done   <= 1'b0;
            r_digest <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_m    <= w_msg_words;
                r_step <= '0;
                if (bus.first) begin
                    r_a  <= IV_A; r_b  <= IV_B; r_c  <= IV_C; r_d  <= IV_D;
                    r_h0 <= IV_A; r_h1 <= IV_B; r_h2 <= IV_C; r_h3 <= IV_D;
                end else begin
                    r_a <= r_h0; r_b <= r_h1; r_c <= r_h2; r_d <= r_h3;
                end
            end else if (r_state == RUN) begin
                r_a    <= w_a;
                r_b    <= w_b;
                r_c    <= w_c;
                r_d    <= w_d;
                r_step <= r_step + 6'(UNROLL);
            end else if (r_state == FINAL) begin
                r_h0     <= w_h0;
                r_h1     <= w_h1;
                r_h2     <= w_h2;
                r_h3     <= w_h3;
                r_digest <= w_digest;
                r_done   <= 1'b1;
            end
        end
    end

    assign bus.busy      = (r_state != IDLE);
    assign bus.done      = r_done;
    assign bus.digest    = r_digest;
    assign bus.state_dbg = r_state;
endmodule

// File: tb/tb_md5_iter_core.sv
// Bench for md5_iter_core at UNROLL 1..16 side by side: known answers, chaining,
// held start, mid-block reset and random blocks against a behavioural MD5 model.
module tb_md5_iter_core;
    typedef logic [3:0][31:0]  h_t;
    typedef logic [15:0][31:0] w_t;
    typedef struct packed {
        logic         fst;
        w_t           w;
        logic [127:0] kat;
    } vec_t;

    localparam int NI  = 5;
    localparam int WIN = 68;
    localparam h_t IV  = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};
    localparam int SH [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
    localparam logic [127:0] KAT_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;
    localparam logic [127:0] KAT_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;
    localparam logic [127:0] KAT_CHAIN = 128'h014842d480b571495a4a0363793f7367;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         first = 1'b0;
    logic [511:0] message = '0;
    logic [NI-1:0] done_v, busy_v;
    logic [127:0] dig_v [NI];
    logic [1:0]   st_v [NI];

    int          checks = 0;
    int          failures = 0;
    logic [31:0] kconst [64];
    h_t          m_h;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        md5_iter_if bus ();
        assign bus.start   = start;
        assign bus.first   = first;
        assign bus.message = message;
        md5_iter_core #(.UNROLL(1 << g)) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus.slave)
        );
        assign done_v[g] = bus.done;
        assign busy_v[g] = bus.busy;
        assign dig_v[g]  = bus.digest;
        assign st_v[g]   = bus.state_dbg;
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [511:0] to_msg(input w_t w);
        logic [511:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) begin
`ifdef MD5_BYTESWAP_EN
            m[511 - 32*i -: 32] = bswap(w[i]);
`else
            m[32*i +: 32] = w[i];
`endif
        end
        return m;
    endfunction

    function automatic logic [127:0] to_digest(input h_t h);
`ifdef MD5_BYTESWAP_EN
        return {bswap(h[0]), bswap(h[1]), bswap(h[2]), bswap(h[3])};
`else
        return {h[0], h[1], h[2], h[3]};
`endif
    endfunction

    // Known answers are written as standard digest bytes.
    function automatic logic [127:0] kat_digest(input logic [127:0] s);
`ifdef MD5_BYTESWAP_EN
        return s;
`else
        return {bswap(s[127:96]), bswap(s[95:64]), bswap(s[63:32]), bswap(s[31:0])};
`endif
    endfunction

    function automatic h_t md5_compress(input h_t h, input w_t w);
        logic [31:0] a, b, c, d, f, t;
        int g, s;
        h_t o;
        a = h[0]; b = h[1]; c = h[2]; d = h[3];
        for (int i = 0; i < 64; i++) begin
            case (i / 16)
                0:       begin f = (b & c) | (~b & d); g = i; end
                1:       begin f = (d & b) | (~d & c); g = (5*i + 1) % 16; end
                2:       begin f = b ^ c ^ d;          g = (3*i + 5) % 16; end
                default: begin f = c ^ (b | ~d);       g = (7*i) % 16; end
            endcase
            s = SH[(i / 16) * 4 + (i % 4)];
            t = a + f + kconst[i] + w[g];
            a = d; d = c; c = b;
            b = b + ((t << s) | (t >> (32 - s)));
        end
        o[0] = h[0] + a; o[1] = h[1] + b; o[2] = h[2] + c; o[3] = h[3] + d;
        return o;
    endfunction

    function automatic w_t rand_words();
        w_t w;
        for (int i = 0; i < 16; i++) w[i] = $urandom();
        return w;
    endfunction

    task automatic check_reset_state(input string tag);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s_busy_u%0d", tag, 1 << k), busy_v[k], 0);
            check($sformatf("%s_done_u%0d", tag, 1 << k), done_v[k], 0);
            check($sformatf("%s_digest_u%0d", tag, 1 << k), dig_v[k], 0);
        end
    endtask

    task automatic run_block(input string name, input logic fst, input w_t w,
                             input logic [127:0] kat, input logic use_kat);
        logic [127:0] exp;
        logic [127:0] got [NI];
        int lat [NI];
        int ndone [NI];
        int berr [NI];
        m_h = md5_compress(fst ? IV : m_h, w);
        exp = to_digest(m_h);
        for (int k = 0; k < NI; k++) begin
            lat[k] = 0; ndone[k] = 0; berr[k] = 0; got[k] = '0;
        end
        @(negedge clk);
        start = 1'b1; first = fst; message = to_msg(w);
        @(posedge clk); #1;
        start = 1'b0; first = 1'($urandom()); message = {16{$urandom()}};
        for (int cyc = 0; cyc <= WIN; cyc++) begin
            if (cyc > 0) begin @(posedge clk); #1; end
            for (int k = 0; k < NI; k++) begin
                if (done_v[k]) begin
                    ndone[k]++;
                    if (lat[k] == 0) begin lat[k] = cyc; got[k] = dig_v[k]; end
                end
                if (busy_v[k] !== (cyc <= (64 >> k))) berr[k]++;
            end
        end
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s_latency_u%0d", name, 1 << k), lat[k], (64 >> k) + 1);
            check($sformatf("%s_done_count_u%0d", name, 1 << k), ndone[k], 1);
            check($sformatf("%s_busy_profile_u%0d", name, 1 << k), berr[k], 0);
            check($sformatf("%s_digest_u%0d", name, 1 << k), got[k], exp);
            check($sformatf("%s_digest_held_u%0d", name, 1 << k), dig_v[k], exp);
            if (use_kat) check($sformatf("%s_kat_u%0d", name, 1 << k), got[k], kat_digest(kat));
        end
    endtask

    initial begin
        real r;
        vec_t vecs [4];
        w_t w_empty, w_abc, w_blk1, w_blk2, w;
        logic [127:0] exp;
        logic [127:0] got [NI];
        logic seen [NI];
        int n0, berr0;

        for (int i = 0; i < 64; i++) begin
            r = $sin(real'(i + 1));
            if (r < 0.0) r = -r;
            kconst[i] = 32'(longint'($floor(r * 4294967296.0)));
        end
        m_h = IV;

        w_empty = '0; w_empty[0] = 32'h00000080;
        w_abc   = '0; w_abc[0]   = 32'h80636261; w_abc[14] = 32'h00000018;
        for (int i = 0; i < 16; i++) w_blk1[i] = 32'h61616161;
        w_blk2  = '0; w_blk2[0]  = 32'h00000080; w_blk2[14] = 32'h00000200;

        vecs[0] = '{fst: 1'b1, w: w_empty, kat: KAT_EMPTY};
        vecs[1] = '{fst: 1'b1, w: w_abc,   kat: KAT_ABC};
        vecs[2] = '{fst: 1'b1, w: w_blk1,  kat: 128'h0};
        vecs[3] = '{fst: 1'b0, w: w_blk2,  kat: KAT_CHAIN};

        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        for (int k = 0; k < NI; k++) check($sformatf("reset_state_idle_u%0d", 1 << k), st_v[k], 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 4; i++)
            run_block($sformatf("vec%0d", i), vecs[i].fst, vecs[i].w, vecs[i].kat, (i != 2));

        run_block("blk2_first1", 1'b1, w_blk2, 128'h0, 1'b0);
        for (int k = 0; k < NI; k++)
            check($sformatf("blk2_first1_differs_u%0d", 1 << k), dig_v[k] != kat_digest(KAT_CHAIN), 1);

        for (int i = 0; i < 8; i++) run_block($sformatf("rand%0d", i), 1'($urandom()), rand_words(), 128'h0, 1'b0);

        // start held high for a whole block with message and first churning.
        w = rand_words();
        exp = to_digest(md5_compress(IV, w));
        for (int k = 0; k < NI; k++) begin seen[k] = 1'b0; got[k] = '0; end
        n0 = 0; berr0 = 0;
        @(negedge clk);
        start = 1'b1; first = 1'b1; message = to_msg(w);
        @(posedge clk); #1;
        for (int cyc = 1; cyc <= 66; cyc++) begin
            message = {16{$urandom()}};
            first = 1'($urandom());
            @(posedge clk); #1;
            for (int k = 0; k < NI; k++)
                if (done_v[k] && !seen[k]) begin seen[k] = 1'b1; got[k] = dig_v[k]; end
            if (done_v[0]) n0++;
            if (cyc <= 65 && busy_v[0] !== (cyc <= 64)) berr0++;
        end
        check("held_reaccept_after_done", busy_v[0], 1);
        check("held_one_done", n0, 1);
        check("held_busy_profile", berr0, 0);
        for (int k = 0; k < NI; k++) check($sformatf("held_digest_u%0d", 1 << k), got[k], exp);
        @(negedge clk);
        start = 1'b0;
        repeat (80) @(posedge clk);

        // Reset while UNROLL=1 is mid-block.
        @(negedge clk);
        start = 1'b1; first = 1'b1; message = to_msg(w_abc);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (31) @(posedge clk);
        #2;
        check("mid_busy_before_reset", busy_v[0], 1);
        reset = 1'b1;
        #1;
        check_reset_state("midrun_reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_h = IV;
        run_block("after_reset_first0", 1'b0, w_abc, KAT_ABC, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/md5_iter_core.md
# md5_iter_core

Parametrised, iterative MD5 compression engine. It processes one 512-bit pre-padded block per `start` and computes UNROLL of the 64 MD5 steps per clock. It keeps the chaining value internally, so multi-block messages hash without external state. It sits between the message padder/block buffer and the digest consumer, and replaces the single-configuration MD5 core.

## Interface
Parameters:
- `UNROLL`, default 1: MD5 steps per clock. Legal values are 1, 2, 4, 8 and 16; any other value fails elaboration.

Ports:
- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request to compress `message`. Sampled only in IDLE.
- `first`, input, 1: sampled with `start`. 1 uses the standard IV; 0 chains from the previous digest.
- `message`, input, 512: padded block. It is captured at the accepting edge, so it does not need to be held afterwards.
- `busy`, output, 1: high from the accepting edge until the digest is updated.
- `done`, output, 1: one-cycle pulse marking a valid `digest`.
- `digest`, output, 128: result of the last completed block. Held until the next completion.

## Operation
- **IV:** A=32'h67452301, B=32'hefcdab89, C=32'h98badcfe, D=32'h10325476.
- **Step constants:** the 64 K constants, the shift amounts and the message-index schedule are standard MD5 (RFC 1321), held in a combinational ROM indexed by step number.
- **States:** IDLE, RUN, FINAL.
- **IDLE, on `start`=1:**
  - latch the 16 message words;
  - load the working registers a/b/c/d from the IV if `first`=1, else from the chaining registers H0..H3;
  - copy the same values into H0..H3 when `first`=1;
  - clear the step counter; go to RUN.
- **RUN:**
  - each cycle, apply UNROLL chained steps, combinationally: step k, k+1, …, k+UNROLL-1;
  - increment the step counter by UNROLL;
  - after the cycle that performs step 63, go to FINAL.
- **FINAL:**
  - H0..H3 <= H + {a,b,c,d}, each add mod 2^32;
  - update `digest` from the new H;
  - pulse `done`; go to IDLE.
- **Arithmetic:** all adds are 32-bit and wrap; rotates are left rotates by the standard amounts. Each round uses its standard function: F for steps 0-15, G for 16-31, H for 32-47, I for 48-63.
- **`start` while busy:** ignored. It is not queued; `message` and `first` are not sampled.
- **`first`=0 after reset:** chains from the IV, because H resets to the IV.
- **Reset at any time, including mid-block:**
  - state goes to IDLE;
  - `busy`=0, `done`=0, `digest`=128'h0;
  - H0..H3 return to the IV;
  - the in-flight block is discarded.

## Timing
- Let N = 64/UNROLL. Call the accepting edge E0.
- RUN occupies edges E1..EN. FINAL is edge EN+1.
- `done` is high for exactly one cycle after EN+1. Latency from the accepting edge to `done` is N+1 cycles: 65, 33, 17, 9 and 5 for UNROLL = 1, 2, 4, 8 and 16.
- `busy` rises after E0 and falls after EN+1, coincident with `done`.
- Back-to-back operation: `start` may be high in the same cycle `done` is high, and is accepted at the next edge. Throughput is one block per N+2 cycles.
- `digest` changes only at FINAL edges and at reset.

## Configuration
- **`MD5_BYTESWAP_EN` defined:**
  - `message` is a byte stream with byte 0 in `message[511:504]`;
  - word i is assembled little-endian from bytes 4i..4i+3;
  - `digest` is byte-swapped per word, so `digest[127:120]` is the first standard digest byte.
- **`MD5_BYTESWAP_EN` undefined:**
  - word i = `message[32i+31:32i]`, used as-is;
  - `digest` = {H0,H1,H2,H3}, with H0 in `[127:96]`.

## Test plan
- **Empty message, macro defined, UNROLL=1:** `message` = byte 0 = 8'h80, all else 0; `first`=1 -> `done` 65 cycles after the accepting edge; `digest` = 128'hd41d8cd98f00b204e9800998ecf8427e.
- **Empty message, macro undefined:** `message[31:0]`=32'h00000080, all else 0 -> `digest` = 128'hd98c1dd404b2008f980980e97e42f8ec.
- **"abc", macro defined, UNROLL = 1, 2, 4:** `message[511:480]`=32'h61626380, `message[63:56]`=8'h18, all else 0 -> `digest` = 128'h900150983cd24fb0d6963f7d28e17f72; `done` latency 65, 33 and 17 cycles respectively.
- **Chaining:** hash a 64-byte "a" message as two blocks (first=1, then first=0) -> digest = 128'h014842d480b571495a4a0363793f7367. Repeat block 2 with first=1 -> result differs.
- **`start` held high through a whole block, with `message` changed mid-block:** one `done` only; digest matches the block captured at E0; a second start is accepted only after `done`.
- **Reset asserted mid-RUN (step 30):** `busy`, `done` and `digest` go to 0 immediately. A subsequent first=0 "abc" block yields the first=1 result.
